// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default width.
package countdown_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, optional auto-reload and a one-cycle done pulse on expiry.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nx;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             r_busy;

    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_reload_nx = r_reload;
        w_done_nx   = 1'b0;
        if (load) begin
            w_count_nx  = load_val;
            w_reload_nx = load_val;
            w_state_nx  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (r_count == '0) w_done_nx  = 1'b1;
                        else               w_state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        w_state_nx = ST_HOLD;
                    end else if (r_count == CNT_ONE) begin
                        // Expiry edge: reload in place, fall back to IDLE if nothing to reload
                        w_done_nx = 1'b1;
                        if (auto_reload && (r_reload != '0)) begin
                            w_count_nx = r_reload;
                        end else begin
                            w_count_nx = r_reload & {WIDTH{auto_reload}};
                            w_state_nx = ST_IDLE;
                        end
                    end else if (r_count == '0) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_count_nx = r_count - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!pause) w_state_nx = ST_RUN;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_reload <= w_reload_nx;
            r_done   <= w_done_nx;
            r_busy   <= (w_state_nx != ST_IDLE);
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign zero  = (r_count == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scenarios plus random traffic, every cycle compared against a behavioural timer model.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         zero;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    // Model: remaining count as an integer, plus "running" and "paused" flags.
    int m_count  = 0;
    int m_reload = 0;
    bit m_run    = 0;
    bit m_hold   = 0;
    bit m_done   = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .auto_reload(auto_reload), .count(count), .busy(busy),
        .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_reload = 0; m_run = 0; m_hold = 0; m_done = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (load) begin
            m_count = int'(load_val); m_reload = m_count; m_run = 0; m_hold = 0;
        end else if (!m_run) begin
            if (start) begin
                if (m_count == 0) m_done = 1;
                else              m_run  = 1;
            end
        end else if (m_hold) begin
            m_hold = pause;
        end else if (pause) begin
            m_hold = 1;
        end else begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_done = 1;
                if (auto_reload) m_count = m_reload;
                m_run = (m_count != 0);
            end
        end
    endtask

    task automatic compare_all();
        chk("count", 32'(count), 32'(m_count));
        chk("busy",  32'(busy),  32'(m_run));
        chk("done",  32'(done),  32'(m_done));
        chk("zero",  32'(zero),  32'(m_count == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (done === 1'b1) n_done++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; pause = 0; auto_reload = 0;
    endtask

    task automatic do_load(input int v);
        load = 1; load_val = W'(v); tick(); load = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #1 rst = 0;
        #1 model_reset();
        compare_all();
        @(negedge clk) rst = 1;
    endtask

    initial begin
        idle_inputs();
        #3;
        model_reset();
        compare_all();
        @(negedge clk) rst = 1;

        // Load 5, start, full countdown
        do_load(5);
        n_done = 0;
        start = 1; tick(); start = 0;
        chk("e0_count_held", 32'(count), 32'd5);
        ticks(5);
        chk("exp5_done_now", 32'(done), 32'd1);
        chk("exp5_busy_low", 32'(busy), 32'd0);
        ticks(2);
        chk("exp5_one_pulse", 32'(n_done), 32'd1);

        // Load 4, pause for 3 cycles at count 2
        do_load(4);
        n_done = 0;
        start = 1; tick(); start = 0;
        ticks(2);
        pause = 1; ticks(3);
        chk("hold_count", 32'(count), 32'd2);
        pause = 0; ticks(3);
        chk("pause_expired", 32'(count), 32'd0);
        ticks(2);
        chk("pause_one_pulse", 32'(n_done), 32'd1);

        // Load 3 with auto-reload: pulse every 3 cycles, busy stays high
        do_load(3);
        auto_reload = 1;
        start = 1; tick(); start = 0;
        n_done = 0;
        ticks(9);
        chk("reload_pulses", 32'(n_done), 32'd3);
        chk("reload_busy", 32'(busy), 32'd1);
        auto_reload = 0;
        ticks(3);

        // Auto-reload with reload value 0 behaves like start at zero
        do_load(0);
        auto_reload = 1;
        n_done = 0;
        start = 1; tick(); start = 0;
        chk("start0_done", 32'(done), 32'd1);
        chk("start0_busy", 32'(busy), 32'd0);
        ticks(2);
        chk("start0_one_pulse", 32'(n_done), 32'd1);
        auto_reload = 0;

        // Load max value: 15 edges to expiry, no wrap
        do_load(15);
        n_done = 0;
        start = 1; tick(); start = 0;
        begin
            int edges = 0;
            while (n_done == 0 && edges < 40) begin tick(); edges++; end
            chk("max_edges", 32'(edges), 32'd15);
        end
        ticks(3);
        chk("max_no_wrap", 32'(count), 32'd0);

        // Reset mid-run at count 3
        do_load(5);
        start = 1; tick(); start = 0;
        ticks(2);
        chk("pre_reset_count", 32'(count), 32'd3);
        n_done = 0;
        async_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        ticks(6);
        chk("rst_no_pulse", 32'(n_done), 32'd0);

        // Load 7 while counting at 2
        do_load(5);
        start = 1; tick(); start = 0;
        ticks(3);
        n_done = 0;
        do_load(7);
        chk("reload_mid_count", 32'(count), 32'd7);
        chk("reload_mid_busy", 32'(busy), 32'd0);
        start = 1; tick(); start = 0;
        ticks(7);
        chk("from7_one_pulse", 32'(n_done), 32'd1);
        chk("from7_zero", 32'(zero), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            load        = ($urandom_range(0, 15) == 0);
            load_val    = W'($urandom_range(0, 15));
            start       = ($urandom_range(0, 3) == 0);
            pause       = ($urandom_range(0, 4) == 0);
            auto_reload = ($urandom_range(0, 2) == 0);
            tick();
            if ($urandom_range(0, 60) == 0) async_reset();
        end
        idle_inputs();
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
